// File: rtl/decode_prefetch_queue.sv
// Prefetch byte queue between instruction fetch and decode: 32-bit words in,
// a masked 8-byte window out, variable-length (1..8 byte) retirement per cycle.
module decode_prefetch_queue #(
   parameter int DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_data,
   output logic        fetch_ready,
   input  logic        consume_valid,
   input  logic [3:0]  consume_count,
   output logic [7:0]  instruction [0:7],
   output logic [4:0]  byte_count,
   output logic        consume_error
);

   logic [7:0] buf_q [0:15];
   logic [7:0] buf_d [0:15];
   logic [3:0] rd_ptr_q, rd_ptr_d;
   logic [3:0] wr_ptr_q, wr_ptr_d;
   logic [4:0] byte_count_q, byte_count_d;
   logic       consume_error_q, consume_error_d;

   logic push;
   logic consume_legal;
   logic consume_ok;

   // Ready looks only at the registered count: bytes freed this cycle do not make room.
   assign fetch_ready = (byte_count_q <= 5'(DEPTH - 4));

   always_comb begin
      consume_legal = (consume_count != 4'd0) && (consume_count <= 4'd8) &&
                      ({1'b0, consume_count} <= byte_count_q);
      push          = fetch_valid && fetch_ready && !flush;
      consume_ok    = consume_valid && consume_legal && !flush;

      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      byte_count_d    = byte_count_q;
      consume_error_d = consume_valid && !consume_legal && !flush;

      if (flush) begin
         rd_ptr_d     = 4'd0;
         wr_ptr_d     = 4'd0;
         byte_count_d = 5'd0;
      end else begin
         if (consume_ok) begin
            rd_ptr_d     = rd_ptr_q + consume_count;
            byte_count_d = byte_count_d - {1'b0, consume_count};
         end
         if (push) begin
            wr_ptr_d     = wr_ptr_q + 4'd4;
            byte_count_d = byte_count_d + 5'd4;
         end
      end
   end

   always_comb begin
      buf_d = buf_q;
      if (push) begin
         for (int k = 0; k < 4; k++) begin
            buf_d[wr_ptr_q + 4'(k)] = fetch_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q        <= 4'd0;
         wr_ptr_q        <= 4'd0;
         byte_count_q    <= 5'd0;
         consume_error_q <= 1'b0;
      end else begin
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         byte_count_q    <= byte_count_d;
         consume_error_q <= consume_error_d;
      end
   end

   // Storage is left unreset; stale bytes are hidden by the window mask below.
   always_ff @(posedge clock) begin
      buf_q <= buf_d;
   end

   for (genvar i = 0; i < 8; i++) begin : g_window
      assign instruction[i] = (5'(i) < byte_count_q) ? buf_q[rd_ptr_q + 4'(i)] : 8'h00;
   end

   assign byte_count    = byte_count_q;
   assign consume_error = consume_error_q;

endmodule

// File: tb/tb_decode_prefetch_queue.sv
// Directed bench for decode_prefetch_queue with a byte-queue reference for the wrap sequence.
module tb_decode_prefetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_ready;
   logic        consume_valid;
   logic [3:0]  consume_count;
   logic [7:0]  instruction [0:7];
   logic [4:0]  byte_count;
   logic        consume_error;

   int total = 0;
   int bad   = 0;

   logic [7:0]  q[$];
   logic [7:0]  nb;
   logic [63:0] exp_win;
   logic        rdy;
   logic        legal;

   decode_prefetch_queue #(.DEPTH(16)) dut (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .fetch_valid(fetch_valid),
      .fetch_data(fetch_data),
      .fetch_ready(fetch_ready),
      .consume_valid(consume_valid),
      .consume_count(consume_count),
      .instruction(instruction),
      .byte_count(byte_count),
      .consume_error(consume_error)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] win();
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = instruction[i];
      return w;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; fetch_valid = 1'b0; consume_valid = 1'b0; consume_count = 4'd0;
   endtask

   task automatic push(input logic [31:0] w);
      fetch_valid = 1'b1; fetch_data = w;
      step();
      fetch_valid = 1'b0;
   endtask

   task automatic consume(input logic [3:0] n);
      consume_valid = 1'b1; consume_count = n;
      step();
      consume_valid = 1'b0; consume_count = 4'd0;
   endtask

   initial begin
      reset = 1'b1; fetch_data = 32'h0;
      idle();
      step();
      check("rst_count", 64'(byte_count), 64'd0);
      check("rst_ready", 64'(fetch_ready), 64'd1);
      check("rst_window", win(), 64'h0);
      check("rst_err", 64'(consume_error), 64'd0);
      reset = 1'b0;
      step();

      push(32'h44332211);
      check("push1_count", 64'(byte_count), 64'd4);
      check("push1_window", win(), 64'h00000000_44332211);

      push(32'h88776655);
      push(32'hCCBBAA99);
      check("push3_count", 64'(byte_count), 64'd12);
      check("push3_ready", 64'(fetch_ready), 64'd1);
      push(32'h00FFEEDD);
      check("full_count", 64'(byte_count), 64'd16);
      check("full_ready", 64'(fetch_ready), 64'd0);
      push(32'hDEADBEEF);
      check("over_count", 64'(byte_count), 64'd16);
      check("over_window", win(), 64'h88776655_44332211);

      consume(4'd4);
      check("c4_count", 64'(byte_count), 64'd12);
      check("c4_window", win(), 64'hCCBBAA99_88776655);

      // push and consume together at count 12
      fetch_valid = 1'b1; fetch_data = 32'h04030201;
      consume_valid = 1'b1; consume_count = 4'd3;
      step();
      idle();
      check("pc_count", 64'(byte_count), 64'd13);
      check("pc_window", win(), 64'hFFEEDDCC_BBAA9988);
      check("pc_ready", 64'(fetch_ready), 64'd0);

      consume(4'd8);
      check("c8_count", 64'(byte_count), 64'd5);
      check("c8_window", win(), 64'h00000004_03020100);
      consume(4'd3);
      check("c3_count", 64'(byte_count), 64'd2);
      check("c3_window", win(), 64'h0403);

      consume(4'd5);
      check("ill5_count", 64'(byte_count), 64'd2);
      check("ill5_window", win(), 64'h0403);
      check("ill5_err", 64'(consume_error), 64'd1);
      step();
      check("ill5_err_drop", 64'(consume_error), 64'd0);
      consume(4'd0);
      check("ill0_err", 64'(consume_error), 64'd1);
      consume(4'd9);
      check("ill9_err", 64'(consume_error), 64'd1);
      check("ill9_count", 64'(byte_count), 64'd2);
      consume_count = 4'd15;
      step();
      check("novalid_err", 64'(consume_error), 64'd0);

      consume(4'd2);
      check("drain_count", 64'(byte_count), 64'd0);
      check("drain_window", win(), 64'h0);
      check("drain_err", 64'(consume_error), 64'd0);

      // push-4 / consume-3 stream across several pointer wraps
      q.delete();
      nb = 8'h30;
      for (int c = 0; c < 20; c++) begin
         rdy   = (q.size() <= 12);
         legal = (q.size() >= 3);
         fetch_valid = 1'b1; fetch_data = {nb + 8'd3, nb + 8'd2, nb + 8'd1, nb};
         consume_valid = 1'b1; consume_count = 4'd3;
         check("wrap_ready", 64'(fetch_ready), 64'(rdy));
         step();
         if (legal) repeat (3) void'(q.pop_front());
         if (rdy) begin
            for (int k = 0; k < 4; k++) q.push_back(nb + 8'(k));
            nb = nb + 8'd4;
         end
         exp_win = 64'h0;
         for (int i = 0; i < 8 && i < q.size(); i++) exp_win[8*i +: 8] = q[i];
         check("wrap_count", 64'(byte_count), 64'(q.size()));
         check("wrap_window", win(), exp_win);
         check("wrap_err", 64'(consume_error), 64'(!legal));
      end
      idle();

      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush0_count", 64'(byte_count), 64'd0);

      push(32'h13121110);
      push(32'h17161514);
      push(32'h1B1A1918);
      consume(4'd3);
      check("pre_flush_count", 64'(byte_count), 64'd9);
      flush = 1'b1; fetch_valid = 1'b1; fetch_data = 32'hA5A5A5A5;
      consume_valid = 1'b1; consume_count = 4'd10;
      step();
      idle();
      check("flush_count", 64'(byte_count), 64'd0);
      check("flush_window", win(), 64'h0);
      check("flush_err", 64'(consume_error), 64'd0);
      check("flush_ready", 64'(fetch_ready), 64'd1);
      push(32'h44332211);
      check("post_flush_window", win(), 64'h00000000_44332211);

      push(32'h88776655);
      check("pre_rst_count", 64'(byte_count), 64'd8);
      fetch_valid = 1'b1; fetch_data = 32'hF3F2F1F0;
      consume_valid = 1'b1; consume_count = 4'd9;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_count", 64'(byte_count), 64'd0);
      check("mid_rst_window", win(), 64'h0);
      check("mid_rst_ready", 64'(fetch_ready), 64'd1);
      check("mid_rst_err", 64'(consume_error), 64'd0);
      #2 reset = 1'b0;
      consume_valid = 1'b0; consume_count = 4'd0;
      step();
      fetch_valid = 1'b0;
      check("post_rst_count", 64'(byte_count), 64'd4);
      check("post_rst_window", win(), 64'h00000000_F3F2F1F0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_prefetch_queue.md
DECODE_PREFETCH_QUEUE -- requirements
Module: decode_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning queue capacity in bytes; only 16 is supported.
REQ-002 SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  synchronous queue discard (branch/jump redirect).
REQ-005 SHALL have port: fetch_valid  input  1  prefetch word offered.
REQ-006 SHALL have port: fetch_data  input  32  prefetch word; byte [7:0] is earliest in program order, [31:24] latest.
REQ-007 SHALL have port: fetch_ready  output  1  queue accepts a word this cycle.
REQ-008 SHALL have port: consume_valid  input  1  decode retires bytes this cycle.
REQ-009 SHALL have port: consume_count  input  4  number of bytes retired, legal range 1..8.
REQ-010 SHALL have port: instruction  output  8 x 8 (unpacked [0:7])  byte window; index 0 is the oldest queued byte; this output feeds the decode stages' instruction input.
REQ-011 SHALL have port: byte_count  output  5  bytes currently held, range 0..16.
REQ-012 SHALL have port: consume_error  output  1  registered one-cycle pulse flagging an illegal consume.

Function
REQ-013 SHALL store bytes in a 16-entry circular byte buffer with 4-bit read and write pointers that wrap modulo 16.
REQ-014 SHALL drive fetch_ready = (byte_count <= 12) combinationally, evaluated before the same-cycle consume (no pass-through credit).
REQ-015 SHALL push on fetch_valid && fetch_ready: 4 bytes written at wr_ptr..wr_ptr+3 (mod 16), fetch_data[7:0] at wr_ptr; wr_ptr += 4.
REQ-016 SHALL accept a consume when consume_valid && 1 <= consume_count <= 8 && consume_count <= byte_count; rd_ptr += consume_count.
REQ-017 SHALL ignore an illegal consume (count 0, >8, or > byte_count); state unchanged; consume_error = 1 next cycle, else 0.
REQ-018 SHALL combine simultaneous push and legal consume in one cycle: byte_count' = byte_count - consume_count + 4; pushed bytes follow the remaining bytes.
REQ-019 SHALL evaluate the consume legality check against the pre-push byte_count; same-cycle pushed bytes are never consumable.
REQ-020 SHALL give flush priority over push and consume: next cycle rd_ptr = wr_ptr = 0, byte_count = 0, consume_error = 0; same-cycle fetch word discarded.
REQ-021 SHALL drive instruction[i] = buffer[rd_ptr+i mod 16] when i < byte_count, else 8'h00; combinational from registered state (zero added latency).
REQ-022 SHALL make a pushed word visible on instruction and byte_count the cycle after acceptance (1-cycle latency).
REQ-023 SHALL hold all state when neither push, legal consume, nor flush occurs.
REQ-024 SHALL never overflow (byte_count <= 16) or underflow (byte_count >= 0) under any input sequence.

Reset
REQ-025 SHALL, while reset = 1, asynchronously force rd_ptr = 0, wr_ptr = 0, byte_count = 0, consume_error = 0; instruction reads all 8'h00; fetch_ready = 1.
REQ-026 SHALL leave buffer byte contents unreset; they are unobservable because of masking in REQ-021.
REQ-027 SHALL abandon any in-flight push/consume when reset asserts mid-cycle; the first post-reset edge behaves as from empty.

Verification
REQ-028 SHALL cover: reset, push 32'h44332211 -> next cycle byte_count = 4, instruction[0:3] = 11,22,33,44, instruction[4:7] = 00.
REQ-029 SHALL cover: push 4 words (16 bytes) -> byte_count = 16, fetch_ready = 0; a 5th fetch_valid is not accepted and state is unchanged.
REQ-030 SHALL cover: byte_count = 12, push and consume_count = 3 in the same cycle -> byte_count = 13 and the window starts at the old 4th byte.
REQ-031 SHALL cover: byte_count = 2, consume_count = 5 -> state unchanged, consume_error = 1 for exactly one cycle.
REQ-032 SHALL cover wrap-around: repeated push-4 / consume-3 for 20 cycles -> window bytes match the reference byte stream across the pointer wrap.
REQ-033 SHALL cover: flush asserted with fetch_valid and consume_valid at byte_count = 9 -> next cycle byte_count = 0, window all 00; reset asserted mid-stream -> outputs zero immediately.
